offset_apply: RTL

Consumer end of the tuning offset produced by the key-driven offset generator. It captures a base time when the system enters clock-tuning or alarm-tuning mode and tracks the biased 20-bit offset while tuning. On leaving the mode, it converts the offset to a signed delta, normalizes base+delta modulo 86400 with a multi-cycle engine, and issues a one-cycle load to the seconds counter or the alarm register.

---
 rtl/offset_apply_if.sv | 26 ++
 rtl/offset_apply.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/offset_apply_if.sv
// offset_apply_if -- bus bundle between the tuning front end and offset_apply.
//   Tuning side (master) drives: sys_status, offset, cur_sec, alarm_sec.
//   offset_apply (slave) drives: load_sec, load_valid, load_target, busy,
//                                preview_sec, preview_valid.
interface offset_apply_if;
  logic [2:0]  sys_status;
  logic [19:0] offset;
  logic [16:0] cur_sec;
  logic [16:0] alarm_sec;
  logic [16:0] load_sec;
  logic        load_valid;
  logic        load_target;
  logic        busy;
  logic [16:0] preview_sec;
  logic        preview_valid;

  modport master (
    output sys_status, offset, cur_sec, alarm_sec,
    input  load_sec, load_valid, load_target, busy, preview_sec, preview_valid
  );

  modport slave (
    input  sys_status, offset, cur_sec, alarm_sec,
    output load_sec, load_valid, load_target, busy, preview_sec, preview_valid
  );
endinterface

// File: rtl/offset_apply.sv
// offset_apply -- applies the biased tuning offset to a captured base time.
// On entry to clock/alarm tuning the base (cur_sec or alarm_sec) is captured.
// On leaving the mode, base + (offset - OFFSET_INIT) is normalized modulo
// DAY_SEC one correction step per cycle, then a one-cycle load strobe is issued.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  sys_status/offset/cur_sec/alarm_sec in;
//                load_sec/load_valid/load_target/busy/preview_sec/preview_valid out
//
// Build option: OFFSET_APPLY_PREVIEW_EN -- when defined, the tuned value is
// normalized continuously during tuning and shown on preview_sec/preview_valid;
// when undefined those outputs are tied to 0.
module offset_apply #(
  parameter logic [2:0]  S_TUNING      = 3'd3,
  parameter logic [2:0]  S_ALARMTUNING = 3'd5,
  parameter logic [19:0] OFFSET_INIT   = 20'h7ffff,
  parameter int unsigned DAY_SEC       = 86400
) (
  input  logic          clk,
  input  logic          rst_n,
  offset_apply_if.slave bus
);

  typedef enum logic [1:0] {IDLE, TRACK, NORM, LOAD} state_t;

  localparam logic signed [20:0] DAY = 21'(DAY_SEC);

  state_t             state_q;
  logic [16:0]        base_q;
  logic               tgt_q;        // 0 = clock counter, 1 = alarm register
  logic signed [20:0] sum_q;
  logic               commit_q;     // current NORM run ends in a load
  logic [16:0]        load_sec_q;
  logic               load_valid_q;
  logic               load_target_q;
  logic               busy_q;

  logic signed [20:0] sum_d;
  logic               in_mode;

`ifdef OFFSET_APPLY_PREVIEW_EN
  logic [16:0] preview_sec_q;
  logic        preview_valid_q;
  logic        pend_q;        // preview run owed for a fresh TRACK entry
  logic [19:0] off_used_q;    // offset the latest preview run was started from
  logic [19:0] off_prev_q;    // offset one cycle ago, for change detection
`endif

  // Unsigned 21-bit arithmetic wraps to the correct two's-complement value,
  // since the true result always lies within -524287..610687.
  always_comb begin
    sum_d   = $signed({4'b0, base_q} + {1'b0, bus.offset} - {1'b0, OFFSET_INIT});
    in_mode = (bus.sys_status == (tgt_q ? S_ALARMTUNING : S_TUNING));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      tgt_q         <= 1'b0;
      sum_q         <= '0;
      commit_q      <= 1'b0;
      load_sec_q    <= '0;
      load_valid_q  <= 1'b0;
      load_target_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef OFFSET_APPLY_PREVIEW_EN
      preview_sec_q   <= '0;
      preview_valid_q <= 1'b0;
      pend_q          <= 1'b0;
      off_used_q      <= '0;
      off_prev_q      <= '0;
`endif
    end else begin
      load_valid_q <= 1'b0;
`ifdef OFFSET_APPLY_PREVIEW_EN
      off_prev_q <= bus.offset;
      if (bus.offset != off_prev_q) preview_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.sys_status == S_TUNING || bus.sys_status == S_ALARMTUNING) begin
            base_q  <= (bus.sys_status == S_ALARMTUNING) ? bus.alarm_sec : bus.cur_sec;
            tgt_q   <= (bus.sys_status == S_ALARMTUNING);
            busy_q  <= 1'b1;
            state_q <= TRACK;
`ifdef OFFSET_APPLY_PREVIEW_EN
            pend_q  <= 1'b1;
`endif
          end
        end

        TRACK: begin
          // Any status other than the captured mode (including a direct
          // switch to the other tuning mode) is an exit.
          if (!in_mode) begin
            if (bus.offset == OFFSET_INIT) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
`ifdef OFFSET_APPLY_PREVIEW_EN
              preview_valid_q <= 1'b0;
`endif
            end else begin
              sum_q    <= sum_d;
              commit_q <= 1'b1;
              state_q  <= NORM;
            end
          end
`ifdef OFFSET_APPLY_PREVIEW_EN
          // Compare against the offset of the last run, not of the last
          // cycle, so a change that landed mid-run is still picked up.
          else if (pend_q || bus.offset != off_used_q) begin
            sum_q      <= sum_d;
            commit_q   <= 1'b0;
            off_used_q <= bus.offset;
            pend_q     <= 1'b0;
            state_q    <= NORM;
          end
`endif
        end

        NORM: begin
          if (sum_q[20]) begin
            sum_q <= sum_q + DAY;
          end else if (sum_q >= DAY) begin
            sum_q <= sum_q - DAY;
          end else if (commit_q) begin
            load_sec_q    <= sum_q[16:0];
            load_target_q <= tgt_q;
            load_valid_q  <= 1'b1;
            state_q       <= LOAD;
          end else begin
`ifdef OFFSET_APPLY_PREVIEW_EN
            preview_sec_q   <= sum_q[16:0];
            preview_valid_q <= (bus.offset == off_used_q);
`endif
            state_q <= TRACK;
          end
        end

        LOAD: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef OFFSET_APPLY_PREVIEW_EN
          preview_valid_q <= 1'b0;
`endif
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.load_sec    = load_sec_q;
  assign bus.load_valid  = load_valid_q;
  assign bus.load_target = load_target_q;
  assign bus.busy        = busy_q;
`ifdef OFFSET_APPLY_PREVIEW_EN
  assign bus.preview_sec   = preview_sec_q;
  assign bus.preview_valid = preview_valid_q;
`else
  assign bus.preview_sec   = '0;
  assign bus.preview_valid = 1'b0;
`endif

endmodule
